pipelined_muldiv_ctrl: RTL
==========================

// Module: pipelined_muldiv_ctrl
// PURPOSE
//  Iterative multiply/divide sequencer with HI/LO registers for the pipelined MIPS core.
//  Sits beside PipelinedALU in EX; accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from ID/EX.
//  Runs a shift-add / restoring shift-subtract loop one bit per cycle.
//  Drives Stall to hazard logic while busy and HI/LO are needed.
// PARAMETERS
//  WIDTH  32  operand width; HI and LO are each WIDTH bits
// PORTS
//  Clk       in   1      clock; all state updates on rising edge
//  Reset     in   1      synchronous, active-high
//  Start     in   1      op valid this cycle (sampled only in IDLE)
//  MulDivOp  in   3      0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO
//  BusA      in   WIDTH  rs: multiplicand / dividend / MTHI-MTLO data
//  BusB      in   WIDTH  rt: multiplier / divisor
//  HiLoRead  in   1      ID/EX instruction is MFHI/MFLO
//  HI        out  WIDTH  HI register (product[63:32] / remainder)
//  LO        out  WIDTH  LO register (product[31:0] / quotient)
//  Busy      out  1      iteration in progress
//  Done      out  1      one-cycle pulse; HI/LO updated on this edge
//  Stall     out  1      Busy & (HiLoRead | Start); combinational
// BEHAVIOUR
//  Reset: state IDLE; HI=LO=0; Busy=Done=0; counter=0. Overrides everything, incl. mid-RUN.
//  FSM IDLE -> RUN -> FIX -> IDLE.
//  IDLE, Start & op 1-4:
//    latch |A|,|B| (signed ops) or A,B (unsigned) and result signs; cnt=0; go RUN; Busy=1.
//  IDLE, Start & MTHI/MTLO:
//    HI/LO <= BusA next edge; no Busy, no Done. NONE/op 7 ignored.
//  RUN: one step per cycle, cnt++; after WIDTH steps (cnt==WIDTH-1) go FIX.
//  FIX: apply signs; HI/LO written; Done=1 for the cycle after FIX edge; Busy drops with it.
//  Latency: Start edge to HI/LO valid = WIDTH+2 edges (34 at default). Back-to-back Start
//    accepted the cycle Done is high (state is IDLE).
//  Start while Busy: ignored; upstream must hold via Stall.
//  Signed result signs: mult product = sA^sB; quotient = sA^sB; remainder = sA.
//  Divide by zero: LO=all ones (unsigned), HI=dividend magnitude, sign fix still applied; no trap.
//  0x80000000 / -1 (DIV): LO=0x80000000, HI=0 (two's-complement wrap, no flag).
//  Product width 2*WIDTH; no overflow defined for MULT/MULTU.
//  HI/LO hold old values during RUN; MFHI/MFLO stalled until Done.
// CONFIGURATION
//  MULDIV_EARLY_OUT_EN defined:
//    multiply leaves RUN as soon as remaining multiplier bits are all zero
//    (product shifted into place in FIX); latency = 2 + index of MSB set in |B|+1, min 3.
//    Divide unchanged.
//  Not defined: fixed WIDTH+2 latency for all ops.
// STRUCTURE
//  Package muldiv_pkg: op encodings (MD_NONE..MD_MTLO), FSM state enum, WIDTH default.
//  Sub-module muldiv_step: combinational single iteration;
//    mult: add/shift of {acc,mplr}; div: trial subtract/shift of {rem,quo}.
//  Top holds FSM, counter, sign bits, HI/LO.
// TESTING
//  MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> Done at edge 34; HI=0xFFFFFFFE LO=0x00000001.
//  MULT A=-3 B=7 -> HI=0xFFFFFFFF LO=0xFFFFFFEB; Stall=1 with HiLoRead during Busy.
//  DIV A=-7 B=2 -> LO=0xFFFFFFFD HI=0xFFFFFFFF; DIVU A=7 B=0 -> LO=0xFFFFFFFF HI=7.
//  DIV A=0x80000000 B=-1 -> LO=0x80000000 HI=0; MTHI 0x1234 then MTLO 0x5678 -> HI/LO next edge.
//  Reset at RUN cnt=10 -> next edge Busy=0 HI=LO=0; new MULTU 3*5 -> LO=15 HI=0.
//  EARLY_OUT: MULTU A=9 B=1 -> LO=9 in 3 edges; Start during Busy ignored, result unchanged.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the EX-stage multiply/divide sequencer.
package muldiv_pkg;

    localparam int unsigned MD_WIDTH = 32;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } md_state_e;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply on {acc,wrk} or restoring divide on {rem,quo}.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] opnd,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] wrk,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] wrk_next
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] sub;
    logic           ge;

    always_comb begin
        sum      = {1'b0, acc} + {1'b0, (wrk[0] ? opnd : '0)};
        shifted  = {acc, wrk[WIDTH-1]};
        ge       = (shifted >= {1'b0, opnd});
        sub      = shifted - {1'b0, opnd};
        acc_next = '0;
        wrk_next = '0;
        if (is_div) begin
            // partial remainder stays below the divisor, so the top bit drops cleanly
            acc_next = ge ? WIDTH'(sub) : WIDTH'(shifted);
            wrk_next = {wrk[WIDTH-2:0], ge};
        end else begin
            acc_next = sum[WIDTH:1];
            wrk_next = {sum[0], wrk[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/pipelined_muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer with HI/LO for the EX stage.
// Define MULDIV_EARLY_OUT_EN to let multiplies finish once the remaining multiplier bits are zero.
module pipelined_muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [2:0]       MulDivOp,
    input  logic [WIDTH-1:0] BusA,
    input  logic [WIDTH-1:0] BusB,
    input  logic             HiLoRead,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             Busy,
    output logic             Done,
    output logic             Stall
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam int unsigned PW = 2 * WIDTH;

    md_state_e        state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] wrk_q, wrk_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic             neg_lo_q, neg_lo_d;
    logic             neg_hi_q, neg_hi_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    md_op_e           op;
    logic             sgn, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] acc_step, wrk_step;
    logic [PW-1:0]    prod;
    logic             last_step;

    assign op = md_op_e'(MulDivOp);

    // Operand magnitudes and signs for the signed variants
    always_comb begin
        sgn   = (op == MD_MULT) || (op == MD_DIV);
        a_neg = sgn & BusA[WIDTH-1];
        b_neg = sgn & BusB[WIDTH-1];
        a_mag = a_neg ? -BusA : BusA;
        b_mag = b_neg ? -BusB : BusB;
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (is_div_q),
        .opnd     (opnd_q),
        .acc      (acc_q),
        .wrk      (wrk_q),
        .acc_next (acc_step),
        .wrk_next (wrk_step)
    );

`ifdef MULDIV_EARLY_OUT_EN
    // Unconsumed multiplier bits live in the low part of wrk; product is realigned in FIX
    logic [WIDTH-1:0] rem_mask;
    assign rem_mask  = {WIDTH{1'b1}} >> (cnt_q + CW'(1));
    assign last_step = (cnt_q == CW'(WIDTH - 1)) ||
                       (!is_div_q && ((wrk_step & rem_mask) == '0));
    assign prod      = {acc_q, wrk_q} >> (CW'(WIDTH) - cnt_q);
`else
    assign last_step = (cnt_q == CW'(WIDTH - 1));
    assign prod      = {acc_q, wrk_q};
`endif

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        acc_d    = acc_q;
        wrk_d    = wrk_q;
        opnd_d   = opnd_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    case (op)
                        MD_MULT, MD_MULTU: begin
                            state_d  = ST_RUN;
                            busy_d   = 1'b1;
                            cnt_d    = '0;
                            acc_d    = '0;
                            is_div_d = 1'b0;
                            opnd_d   = a_mag;
                            wrk_d    = b_mag;
                            neg_lo_d = a_neg ^ b_neg;
                            neg_hi_d = a_neg ^ b_neg;
                        end
                        MD_DIV, MD_DIVU: begin
                            state_d  = ST_RUN;
                            busy_d   = 1'b1;
                            cnt_d    = '0;
                            acc_d    = '0;
                            is_div_d = 1'b1;
                            opnd_d   = b_mag;
                            wrk_d    = a_mag;
                            neg_lo_d = a_neg ^ b_neg;
                            neg_hi_d = a_neg;
                        end
                        MD_MTHI: hi_d = BusA;
                        MD_MTLO: lo_d = BusA;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                acc_d = acc_step;
                wrk_d = wrk_step;
                cnt_d = cnt_q + CW'(1);
                if (last_step) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                if (is_div_q) begin
                    lo_d = neg_lo_q ? -wrk_q : wrk_q;
                    hi_d = neg_hi_q ? -acc_q : acc_q;
                end else begin
                    {hi_d, lo_d} = neg_lo_q ? -prod : prod;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            hi_q     <= '0;
            lo_q     <= '0;
            acc_q    <= '0;
            wrk_q    <= '0;
            opnd_q   <= '0;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            acc_q    <= acc_d;
            wrk_q    <= wrk_d;
            opnd_q   <= opnd_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign HI    = hi_q;
    assign LO    = lo_q;
    assign Busy  = busy_q;
    assign Done  = done_q;
    assign Stall = busy_q & (HiLoRead | Start);

endmodule
